// File: rtl/worker_result_merger_if.sv
// Handshake bundle between the worker array, the merger and the consumer.
// Worker side is a VALID/READY slot vector; the consumer side is one stream.
interface worker_result_merger_if #(
  parameter int NUM_WORKERS         = 4,
  parameter int FIFO_AW             = 2,
  parameter int WORKER_RESULT_WIDTH = 8
) ();

  logic [NUM_WORKERS-1:0]                     WR_VALID;
  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] WR_DATA;
  logic [NUM_WORKERS-1:0]                     WR_READY;
  logic                                       MR_VALID;
  logic [WORKER_RESULT_WIDTH-1:0]             MR_DATA;
  logic                                       MR_READY;
  logic [FIFO_AW:0]                           MR_COUNT;

  modport slave (
    input  WR_VALID,
    input  WR_DATA,
    input  MR_READY,
    output WR_READY,
    output MR_VALID,
    output MR_DATA,
    output MR_COUNT
  );

  modport master (
    output WR_VALID,
    output WR_DATA,
    output MR_READY,
    input  WR_READY,
    input  MR_VALID,
    input  MR_DATA,
    input  MR_COUNT
  );

endinterface

// File: rtl/worker_result_merger.sv
// Round-robin merge of worker results into a small FIFO feeding one
// ordered output stream.
module worker_result_merger #(
  parameter int NUM_WORKERS         = 4,
  parameter int FIFO_DEPTH          = 4,
  parameter int FIFO_AW             = 2,
  parameter int WORKER_RESULT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  worker_result_merger_if.slave bus
);

  localparam int RRW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int W   = WORKER_RESULT_WIDTH;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [RRW-1:0]   LAST_W   = RRW'(NUM_WORKERS-1);

  logic [W-1:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RRW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [RRW-1:0]         grant;
  logic                   found;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [NUM_WORKERS-1:0] wr_ready;
  int                     idx;

  // Scan starts at rr_ptr so the last winner goes to the back of the line.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_WORKERS) idx = idx - NUM_WORKERS;
      if (!found && bus.WR_VALID[RRW'(idx)]) begin
        grant = RRW'(idx);
        found = 1'b1;
      end
    end
  end

  // A full FIFO blocks inputs even when a pop lands in the same cycle.
  assign full = (count_q == FULL_CNT);
  assign push = found && !full && !RST;
  assign pop  = (count_q != '0) && bus.MR_READY;

  always_comb begin
    wr_ready = '0;
    if (push) wr_ready[grant] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      rr_ptr_d = (grant == LAST_W) ? '0 : grant + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      pop && !push: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.WR_DATA[grant*W +: W];
  end

  assign bus.WR_READY = wr_ready;
  assign bus.MR_VALID = (count_q != '0);
  assign bus.MR_DATA  = mem_q[rd_ptr_q];
  assign bus.MR_COUNT = count_q;

endmodule

// File: tb/tb_worker_result_merger.sv
// Directed checks of arbitration, FIFO ordering, full/empty and reset
// behaviour of worker_result_merger.
module tb_worker_result_merger;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  worker_result_merger_if #(
    .NUM_WORKERS(4),
    .FIFO_AW(2),
    .WORKER_RESULT_WIDTH(8)
  ) bus ();

  worker_result_merger #(
    .NUM_WORKERS(4),
    .FIFO_DEPTH(4),
    .FIFO_AW(2),
    .WORKER_RESULT_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input int w, input logic [7:0] d);
    bus.WR_DATA[w*8 +: 8] = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST          = 1'b1;
    bus.WR_VALID = 4'hF;
    bus.WR_DATA  = '0;
    bus.MR_READY = 1'b0;

    cyc();
    cyc();
    chk("rst_ready", 32'(bus.WR_READY), 32'h0);
    chk("rst_valid", 32'(bus.MR_VALID), 32'h0);
    chk("rst_count", 32'(bus.MR_COUNT), 32'h0);

    RST          = 1'b0;
    bus.WR_VALID = 4'b0100;
    set_word(2, 8'hA5);
    bus.MR_READY = 1'b1;
    #1;
    chk("single_ready", 32'(bus.WR_READY), 32'h4);
    cyc();
    bus.WR_VALID = 4'b0000;
    #1;
    chk("single_valid", 32'(bus.MR_VALID), 32'h1);
    chk("single_data", 32'(bus.MR_DATA), 32'hA5);
    chk("single_cnt1", 32'(bus.MR_COUNT), 32'h1);
    chk("single_noready", 32'(bus.WR_READY), 32'h0);
    cyc();
    chk("single_cnt0", 32'(bus.MR_COUNT), 32'h0);
    chk("single_empty", 32'(bus.MR_VALID), 32'h0);

    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int w = 0; w < 4; w++) set_word(w, 8'(8'h10 + w));
    bus.WR_VALID = 4'hF;
    bus.MR_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_grant", 32'(bus.WR_READY), 32'(1 << (i % 4)));
      if (i > 0) begin
        chk("rr_data", 32'(bus.MR_DATA), 32'(8'h10 + ((i - 1) % 4)));
        chk("rr_count", 32'(bus.MR_COUNT), 32'h1);
      end
      cyc();
    end
    bus.WR_VALID = 4'h0;
    #1;
    chk("rr_last", 32'(bus.MR_DATA), 32'h13);
    cyc();
    chk("rr_drained", 32'(bus.MR_COUNT), 32'h0);

    bus.MR_READY = 1'b0;
    for (int w = 0; w < 4; w++) set_word(w, 8'(8'h20 + w));
    bus.WR_VALID = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_fill", 32'(bus.WR_READY), 32'(1 << i));
      cyc();
    end
    #1;
    chk("full_count", 32'(bus.MR_COUNT), 32'h4);
    chk("full_block", 32'(bus.WR_READY), 32'h0);
    chk("full_head", 32'(bus.MR_DATA), 32'h20);
    bus.MR_READY = 1'b1;
    #1;
    chk("full_nobypass", 32'(bus.WR_READY), 32'h0);
    cyc();
    bus.MR_READY = 1'b0;
    set_word(1, 8'h31);
    bus.WR_VALID = 4'b0110;
    #1;
    chk("full_cnt3", 32'(bus.MR_COUNT), 32'h3);
    chk("full_next", 32'(bus.WR_READY), 32'h2);
    cyc();
    bus.WR_VALID = 4'h0;
    bus.MR_READY = 1'b1;
    #1;
    chk("full_cnt4", 32'(bus.MR_COUNT), 32'h4);
    chk("drain0", 32'(bus.MR_DATA), 32'h21);
    cyc();
    chk("drain1", 32'(bus.MR_DATA), 32'h22);
    cyc();
    chk("drain2", 32'(bus.MR_DATA), 32'h23);
    cyc();
    chk("drain3", 32'(bus.MR_DATA), 32'h31);
    cyc();
    chk("drain_cnt", 32'(bus.MR_COUNT), 32'h0);

    bus.MR_READY = 1'b0;
    bus.WR_VALID = 4'b0100;
    set_word(2, 8'h40);
    cyc();
    set_word(2, 8'h41);
    cyc();
    bus.MR_READY = 1'b1;
    for (int k = 2; k < 10; k++) begin
      set_word(2, 8'(8'h40 + k));
      #1;
      chk("pp_count", 32'(bus.MR_COUNT), 32'h2);
      chk("pp_data", 32'(bus.MR_DATA), 32'(8'h40 + k - 2));
      chk("pp_ready", 32'(bus.WR_READY), 32'h4);
      cyc();
    end
    bus.WR_VALID = 4'h0;
    #1;
    chk("pp_tail0", 32'(bus.MR_DATA), 32'h48);
    cyc();
    chk("pp_tail1", 32'(bus.MR_DATA), 32'h49);
    cyc();
    chk("pp_empty", 32'(bus.MR_COUNT), 32'h0);

    bus.MR_READY = 1'b0;
    bus.WR_VALID = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      set_word(0, 8'(8'h50 + k));
      cyc();
    end
    chk("mid_cnt3", 32'(bus.MR_COUNT), 32'h3);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    bus.WR_VALID = 4'h0;
    #1;
    chk("mid_valid", 32'(bus.MR_VALID), 32'h0);
    chk("mid_count", 32'(bus.MR_COUNT), 32'h0);
    bus.WR_VALID = 4'hF;
    #1;
    chk("mid_rr0", 32'(bus.WR_READY), 32'h1);
    bus.WR_VALID = 4'b0010;
    set_word(1, 8'h60);
    #1;
    chk("mid_grant1", 32'(bus.WR_READY), 32'h2);
    cyc();
    bus.WR_VALID = 4'h0;
    #1;
    chk("mid_outv", 32'(bus.MR_VALID), 32'h1);
    chk("mid_outd", 32'(bus.MR_DATA), 32'h60);
    chk("mid_outc", 32'(bus.MR_COUNT), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
